// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: opcodes, bus-FSM states, flag positions, ALU ops and the
// instruction decoder shared by the cpu6502 core.
package cpu6502_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_OPER  = 2'd1,
      ST_ADH   = 2'd2,
      ST_MEM   = 2'd3
   } state_e;

   typedef enum logic [3:0] {
      ALU_PASS, ALU_ADC, ALU_SBC, ALU_AND, ALU_ORA,
      ALU_EOR, ALU_CMP, ALU_INC, ALU_DEC
   } alu_op_e;

   // Bit positions inside the 8-bit P register (6502 layout).
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 6;
   localparam int FLAG_N = 7;

   localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDA_ABS = 8'hAD;
   localparam logic [7:0] OP_LDX_IMM = 8'hA2, OP_LDX_ABS = 8'hAE;
   localparam logic [7:0] OP_LDY_IMM = 8'hA0, OP_LDY_ABS = 8'hAC;
   localparam logic [7:0] OP_STA_ABS = 8'h8D, OP_STX_ABS = 8'h8E, OP_STY_ABS = 8'h8C;
   localparam logic [7:0] OP_ADC_IMM = 8'h69, OP_ADC_ABS = 8'h6D, OP_SBC_IMM = 8'hE9;
   localparam logic [7:0] OP_AND_IMM = 8'h29, OP_ORA_IMM = 8'h09, OP_EOR_IMM = 8'h49;
   localparam logic [7:0] OP_CMP_IMM = 8'hC9;
   localparam logic [7:0] OP_INX = 8'hE8, OP_INY = 8'hC8, OP_DEX = 8'hCA, OP_DEY = 8'h88;
   localparam logic [7:0] OP_TAX = 8'hAA, OP_TAY = 8'hA8, OP_TXA = 8'h8A, OP_TYA = 8'h98;
   localparam logic [7:0] OP_CLC = 8'h18, OP_SEC = 8'h38, OP_JMP_ABS = 8'h4C;
   localparam logic [7:0] OP_BEQ = 8'hF0, OP_BNE = 8'hD0, OP_BCC = 8'h90, OP_BCS = 8'hB0;
   localparam logic [7:0] OP_NOP = 8'hEA;

   typedef enum logic [2:0] {CL_IMPL, CL_IMM, CL_ABS, CL_BRA, CL_JMP} iclass_e;
   typedef enum logic [1:0] {R_NONE, R_A, R_X, R_Y} reg_e;

   // a_src feeds the ALU a input and is also the store source;
   // b_src = R_NONE means the ALU b input is the bus data.
   typedef struct packed {
      iclass_e cls;
      alu_op_e op;
      reg_e    a_src;
      reg_e    b_src;
      reg_e    dst;
      logic    wr_nz;
      logic    wr_c;
      logic    wr_v;
      logic    store;
      logic    clc;
      logic    sec;
   } dec_t;

   // Unlisted opcodes fall through as implied NOPs.
   function automatic dec_t decode(input logic [7:0] op);
      dec_t d;
      d       = '0;
      d.cls   = CL_IMPL;
      d.op    = ALU_PASS;
      d.a_src = R_NONE;
      d.b_src = R_NONE;
      d.dst   = R_NONE;
      case (op)
         OP_LDA_IMM: begin d.cls = CL_IMM; d.dst = R_A; d.wr_nz = 1'b1; end
         OP_LDA_ABS: begin d.cls = CL_ABS; d.dst = R_A; d.wr_nz = 1'b1; end
         OP_LDX_IMM: begin d.cls = CL_IMM; d.dst = R_X; d.wr_nz = 1'b1; end
         OP_LDX_ABS: begin d.cls = CL_ABS; d.dst = R_X; d.wr_nz = 1'b1; end
         OP_LDY_IMM: begin d.cls = CL_IMM; d.dst = R_Y; d.wr_nz = 1'b1; end
         OP_LDY_ABS: begin d.cls = CL_ABS; d.dst = R_Y; d.wr_nz = 1'b1; end
         OP_STA_ABS: begin d.cls = CL_ABS; d.store = 1'b1; d.a_src = R_A; end
         OP_STX_ABS: begin d.cls = CL_ABS; d.store = 1'b1; d.a_src = R_X; end
         OP_STY_ABS: begin d.cls = CL_ABS; d.store = 1'b1; d.a_src = R_Y; end
         OP_ADC_IMM, OP_ADC_ABS, OP_SBC_IMM: begin
            d.cls   = (op == OP_ADC_ABS) ? CL_ABS : CL_IMM;
            d.op    = (op == OP_SBC_IMM) ? ALU_SBC : ALU_ADC;
            d.a_src = R_A; d.dst = R_A;
            d.wr_nz = 1'b1; d.wr_c = 1'b1; d.wr_v = 1'b1;
         end
         OP_AND_IMM: begin d.cls = CL_IMM; d.op = ALU_AND; d.a_src = R_A; d.dst = R_A; d.wr_nz = 1'b1; end
         OP_ORA_IMM: begin d.cls = CL_IMM; d.op = ALU_ORA; d.a_src = R_A; d.dst = R_A; d.wr_nz = 1'b1; end
         OP_EOR_IMM: begin d.cls = CL_IMM; d.op = ALU_EOR; d.a_src = R_A; d.dst = R_A; d.wr_nz = 1'b1; end
         OP_CMP_IMM: begin d.cls = CL_IMM; d.op = ALU_CMP; d.a_src = R_A; d.wr_nz = 1'b1; d.wr_c = 1'b1; end
         OP_INX: begin d.op = ALU_INC; d.a_src = R_X; d.dst = R_X; d.wr_nz = 1'b1; end
         OP_INY: begin d.op = ALU_INC; d.a_src = R_Y; d.dst = R_Y; d.wr_nz = 1'b1; end
         OP_DEX: begin d.op = ALU_DEC; d.a_src = R_X; d.dst = R_X; d.wr_nz = 1'b1; end
         OP_DEY: begin d.op = ALU_DEC; d.a_src = R_Y; d.dst = R_Y; d.wr_nz = 1'b1; end
         OP_TAX: begin d.b_src = R_A; d.dst = R_X; d.wr_nz = 1'b1; end
         OP_TAY: begin d.b_src = R_A; d.dst = R_Y; d.wr_nz = 1'b1; end
         OP_TXA: begin d.b_src = R_X; d.dst = R_A; d.wr_nz = 1'b1; end
         OP_TYA: begin d.b_src = R_Y; d.dst = R_A; d.wr_nz = 1'b1; end
         OP_CLC: d.clc = 1'b1;
         OP_SEC: d.sec = 1'b1;
         OP_JMP_ABS: d.cls = CL_JMP;
         OP_BEQ, OP_BNE, OP_BCC, OP_BCS: d.cls = CL_BRA;
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cpu6502_alu.sv
// cpu6502_alu: combinational 8-bit ALU with binary add/subtract, logic ops,
// compare and increment/decrement, producing N, Z, C, V.
module cpu6502_alu
   import cpu6502_pkg::*;
(
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       c_i,
   input  alu_op_e    op_i,
   output logic [7:0] res_o,
   output logic       n_o,
   output logic       z_o,
   output logic       c_o,
   output logic       v_o
);

   logic [7:0] b_eff;
   logic       cin_eff;
   logic [8:0] sum;

   // Subtract and compare reuse the adder as a + ~b + cin; compare forces cin=1.
   always_comb begin
      b_eff   = (op_i == ALU_SBC || op_i == ALU_CMP) ? ~b_i : b_i;
      cin_eff = (op_i == ALU_CMP) ? 1'b1 : c_i;
      sum     = {1'b0, a_i} + {1'b0, b_eff} + {8'd0, cin_eff};
      res_o   = b_i;
      c_o     = c_i;
      v_o     = 1'b0;
      case (op_i)
         ALU_ADC, ALU_SBC: begin
            res_o = sum[7:0];
            c_o   = sum[8];
            v_o   = (a_i[7] == b_eff[7]) && (sum[7] != a_i[7]);
         end
         ALU_CMP: begin
            res_o = sum[7:0];
            c_o   = sum[8];
         end
         ALU_AND: res_o = a_i & b_i;
         ALU_ORA: res_o = a_i | b_i;
         ALU_EOR: res_o = a_i ^ b_i;
         ALU_INC: res_o = a_i + 8'd1;
         ALU_DEC: res_o = a_i - 8'd1;
         default: res_o = b_i;
      endcase
      n_o = res_o[7];
      z_o = (res_o == 8'h00);
   end

endmodule

// File: rtl/cpu6502.sv
// cpu6502: minimal multi-cycle 6502-subset core, one bus access per clock.
// FETCH -> OPER -> (ADH -> MEM) | FETCH; the tri-state data driver lives here.
module cpu6502
   import cpu6502_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] addr,
   inout  wire  [7:0]  data,
   output logic        rw
);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d, pc_inc;
   logic [7:0]  ir_q, ir_d, a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d;
   logic [7:0]  adl_q, adl_d, adh_q, adh_d;
   dec_t        dec;
   logic [7:0]  alu_a, alu_b, alu_res, dout;
   logic        alu_n, alu_z, alu_c, alu_v;
   logic        exec, taken;

   function automatic logic [7:0] reg_sel(input reg_e r, input logic [7:0] a, input logic [7:0] x,
                                          input logic [7:0] y);
      case (r)
         R_A:     return a;
         R_X:     return x;
         R_Y:     return y;
         default: return 8'h00;
      endcase
   endfunction

   assign dec   = decode(ir_q);
   assign dout  = reg_sel(dec.a_src, a_q, x_q, y_q);
   assign alu_a = dout;
   assign alu_b = (dec.b_src == R_NONE) ? data : reg_sel(dec.b_src, a_q, x_q, y_q);

   // Bus outputs derive only from registered state, so they move just after clock edges
   // and collapse to the reset pattern as soon as the async reset clears the registers.
   assign rw   = !(state_q == ST_MEM && dec.store);
   assign addr = (state_q == ST_MEM) ? {adh_q, adl_q} : pc_q;
   assign data = rw ? 8'hzz : dout;

   cpu6502_alu u_alu (
      .a_i  (alu_a),
      .b_i  (alu_b),
      .c_i  (p_q[FLAG_C]),
      .op_i (dec.op),
      .res_o(alu_res),
      .n_o  (alu_n),
      .z_o  (alu_z),
      .c_o  (alu_c),
      .v_o  (alu_v)
   );

   // Bus FSM sequencing, PC update and register/flag write-back.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      x_d     = x_q;
      y_d     = y_q;
      p_d     = p_q;
      adl_d   = adl_q;
      adh_d   = adh_q;
      exec    = 1'b0;
      pc_inc  = pc_q + 16'd1;
      // Opcode bit 6 picks Z (1) or C (0); bit 5 is the value that takes the branch.
      taken   = (ir_q[6] ? p_q[FLAG_Z] : p_q[FLAG_C]) == ir_q[5];
      case (state_q)
         ST_FETCH: begin
            ir_d    = data;
            pc_d    = pc_inc;
            state_d = ST_OPER;
         end
         ST_OPER: begin
            state_d = ST_FETCH;
            case (dec.cls)
               CL_IMM: begin
                  pc_d = pc_inc;
                  exec = 1'b1;
               end
               CL_ABS, CL_JMP: begin
                  adl_d   = data;
                  pc_d    = pc_inc;
                  state_d = ST_ADH;
               end
               CL_BRA: pc_d = taken ? pc_inc + {{8{data[7]}}, data} : pc_inc;
               default: exec = 1'b1;
            endcase
         end
         ST_ADH: begin
            adh_d = data;
            if (dec.cls == CL_JMP) begin
               pc_d    = {data, adl_q};
               state_d = ST_FETCH;
            end else begin
               pc_d    = pc_inc;
               state_d = ST_MEM;
            end
         end
         default: begin
            exec    = !dec.store;
            state_d = ST_FETCH;
         end
      endcase
      if (exec) begin
         case (dec.dst)
            R_A:     a_d = alu_res;
            R_X:     x_d = alu_res;
            R_Y:     y_d = alu_res;
            default: ;
         endcase
         if (dec.wr_nz) begin
            p_d[FLAG_N] = alu_n;
            p_d[FLAG_Z] = alu_z;
         end
         if (dec.wr_c) p_d[FLAG_C] = alu_c;
         if (dec.wr_v) p_d[FLAG_V] = alu_v;
         if (dec.clc)  p_d[FLAG_C] = 1'b0;
         if (dec.sec)  p_d[FLAG_C] = 1'b1;
      end
   end

   // Architectural and FSM state; reset abandons any in-flight instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         pc_q    <= 16'h0000;
         ir_q    <= 8'h00;
         a_q     <= 8'h00;
         x_q     <= 8'h00;
         y_q     <= 8'h00;
         p_q     <= 8'h00;
         adl_q   <= 8'h00;
         adh_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         x_q     <= x_d;
         y_q     <= y_d;
         p_q     <= p_d;
         adl_q   <= adl_d;
         adh_q   <= adh_d;
      end
   end

endmodule

// File: tb/tb_cpu6502.sv
// tb_cpu6502: bench for the cpu6502 core with a 64 KiB read-only memory model.
module tb_cpu6502;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   wire  [15:0] addr;
   wire  [7:0]  data;
   wire         rw;

   logic [7:0]  mem [0:65535];
   int          total = 0;
   int          bad = 0;
   int          wr_cnt = 0;

   logic [15:0] tr_addr [0:511];
   logic        tr_rw   [0:511];
   logic [7:0]  tr_data [0:511];

   // expected bus cycles and registers from the instruction-level model
   logic [15:0] e_addr[$];
   logic        e_rw[$];
   logic [7:0]  e_data[$];
   logic [7:0]  m_a, m_x, m_y;
   logic        m_n, m_v, m_z, m_c;

   logic [7:0]  op_tab [0:30];

   wire [3:0] nvzc = {dut.p_q[7], dut.p_q[6], dut.p_q[1], dut.p_q[0]};

   assign data = rw ? mem[addr] : 8'hzz;

   cpu6502 dut (
      .clk  (clk),
      .reset(reset),
      .addr (addr),
      .data (data),
      .rw   (rw)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!rw) wr_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic hold_reset();
      reset = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // record n bus cycles, sampling mid-cycle; returns at the negedge after n rising edges
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         tr_addr[i] = addr;
         tr_rw[i]   = rw;
         tr_data[i] = data;
         @(negedge clk);
      end
   endtask

   task automatic chk_cyc(input string nm, input int i, input logic [15:0] ea, input logic er);
      check($sformatf("%s cyc%0d addr/rw", nm, i), {tr_addr[i], 15'd0, tr_rw[i]}, {ea, 15'd0, er});
   endtask

   // ---------------- reference model ----------------
   task automatic mbus(input logic [15:0] ad, input logic r, input logic [7:0] d);
      e_addr.push_back(ad);
      e_rw.push_back(r);
      e_data.push_back(d);
   endtask

   task automatic set_nz(input logic [7:0] r);
      m_n = r[7];
      m_z = (r == 8'h00);
   endtask

   task automatic m_adc(input logic [7:0] m);
      int         s;
      logic [7:0] r;
      s   = int'(m_a) + int'(m) + int'(m_c);
      r   = s[7:0];
      m_v = (((m_a ^ r) & (m ^ r)) & 8'h80) != 8'h00;
      m_c = (s > 255);
      m_a = r;
      set_nz(r);
   endtask

   task automatic m_exec(input logic [7:0] op, input logic [7:0] v);
      case (op)
         8'hA9, 8'hAD: begin m_a = v; set_nz(v); end
         8'hA2, 8'hAE: begin m_x = v; set_nz(v); end
         8'hA0, 8'hAC: begin m_y = v; set_nz(v); end
         8'h69, 8'h6D: m_adc(v);
         8'hE9: m_adc(~v);
         8'h29: begin m_a = m_a & v; set_nz(m_a); end
         8'h09: begin m_a = m_a | v; set_nz(m_a); end
         8'h49: begin m_a = m_a ^ v; set_nz(m_a); end
         8'hC9: begin m_c = (m_a >= v); set_nz(m_a - v); end
         8'hE8: begin m_x = m_x + 8'd1; set_nz(m_x); end
         8'hC8: begin m_y = m_y + 8'd1; set_nz(m_y); end
         8'hCA: begin m_x = m_x - 8'd1; set_nz(m_x); end
         8'h88: begin m_y = m_y - 8'd1; set_nz(m_y); end
         8'hAA: begin m_x = m_a; set_nz(m_x); end
         8'hA8: begin m_y = m_a; set_nz(m_y); end
         8'h8A: begin m_a = m_x; set_nz(m_a); end
         8'h98: begin m_a = m_y; set_nz(m_a); end
         8'h18: m_c = 1'b0;
         8'h38: m_c = 1'b1;
         default: ;
      endcase
   endtask

   // run whole instructions from reset until at least max_cycles bus cycles exist
   task automatic model_run(input int max_cycles);
      logic [15:0] pc, ea;
      logic [7:0]  op, v, lo, hi;
      logic        tk;
      e_addr.delete(); e_rw.delete(); e_data.delete();
      m_a = 0; m_x = 0; m_y = 0; m_n = 0; m_v = 0; m_z = 0; m_c = 0;
      pc = 16'h0000;
      while (e_addr.size() < max_cycles) begin
         op = mem[pc]; mbus(pc, 1'b1, op); pc++;
         case (op)
            8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9: begin
               v = mem[pc]; mbus(pc, 1'b1, v); pc++;
               m_exec(op, v);
            end
            8'hAD, 8'hAE, 8'hAC, 8'h6D, 8'h8D, 8'h8E, 8'h8C, 8'h4C: begin
               lo = mem[pc]; mbus(pc, 1'b1, lo); pc++;
               hi = mem[pc]; mbus(pc, 1'b1, hi); pc++;
               ea = {hi, lo};
               if (op == 8'h4C) pc = ea;
               else if (op == 8'h8D) mbus(ea, 1'b0, m_a);
               else if (op == 8'h8E) mbus(ea, 1'b0, m_x);
               else if (op == 8'h8C) mbus(ea, 1'b0, m_y);
               else begin
                  v = mem[ea]; mbus(ea, 1'b1, v);
                  m_exec(op, v);
               end
            end
            8'hF0, 8'hD0, 8'h90, 8'hB0: begin
               v = mem[pc]; mbus(pc, 1'b1, v); pc++;
               case (op)
                  8'hF0: tk = m_z;
                  8'hD0: tk = !m_z;
                  8'h90: tk = !m_c;
                  default: tk = m_c;
               endcase
               if (tk) pc = 16'(int'(pc) + int'($signed(v)));
            end
            default: begin
               mbus(pc, 1'b1, mem[pc]);
               m_exec(op, 8'h00);
            end
         endcase
      end
   endtask

   // ---------------- table of immediate ALU vectors ----------------
   typedef struct {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] m;
      logic       cin;
      logic [7:0] exp_a;
      logic [3:0] exp_nvzc;
   } vec_t;

   vec_t vecs [0:11];

   initial begin
      int n;
      op_tab = '{8'hA9, 8'hAD, 8'hA2, 8'hAE, 8'hA0, 8'hAC, 8'h8D, 8'h8E, 8'h8C, 8'h69, 8'h6D,
                 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9, 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'hA8,
                 8'h8A, 8'h98, 8'h18, 8'h38, 8'h4C, 8'hF0, 8'hD0, 8'h90, 8'hB0};
      vecs[0]  = '{8'h69, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100};
      vecs[1]  = '{8'h69, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011};
      vecs[2]  = '{8'h69, 8'h80, 8'h80, 1'b1, 8'h01, 4'b0101};
      vecs[3]  = '{8'hE9, 8'h50, 8'h10, 1'b1, 8'h40, 4'b0001};
      vecs[4]  = '{8'hE9, 8'h50, 8'hB0, 1'b1, 8'hA0, 4'b1100};
      vecs[5]  = '{8'hE9, 8'h00, 8'h01, 1'b0, 8'hFE, 4'b1000};
      vecs[6]  = '{8'h29, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0001};
      vecs[7]  = '{8'h09, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0010};
      vecs[8]  = '{8'h49, 8'hFF, 8'h0F, 1'b0, 8'hF0, 4'b1000};
      vecs[9]  = '{8'hC9, 8'h40, 8'h40, 1'b0, 8'h40, 4'b0011};
      vecs[10] = '{8'hC9, 8'h40, 8'h41, 1'b1, 8'h40, 4'b1000};
      vecs[11] = '{8'hC9, 8'h40, 8'h10, 1'b0, 8'h40, 4'b0001};

      // reset state
      #2 reset = 1'b0;
      hold_reset();
      repeat (2) @(negedge clk);
      #1;
      check("reset addr", {16'd0, addr}, 32'h0000);
      check("reset rw", {31'd0, rw}, 32'd1);
      check("reset regs", {dut.a_q, dut.x_q, dut.y_q, dut.p_q}, 32'h0);
      check("reset pc", {16'd0, dut.pc_q}, 32'h0);

      // LDA $1234 absolute load
      hold_reset();
      mem[0] = 8'hAD; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h1234] = 8'h5A;
      release_reset();
      run_cycles(5);
      chk_cyc("lda_abs", 0, 16'h0000, 1'b1);
      chk_cyc("lda_abs", 1, 16'h0001, 1'b1);
      chk_cyc("lda_abs", 2, 16'h0002, 1'b1);
      chk_cyc("lda_abs", 3, 16'h1234, 1'b1);
      chk_cyc("lda_abs", 4, 16'h0003, 1'b1);
      check("lda_abs A", {24'd0, dut.a_q}, 32'h5A);
      check("lda_abs NVZC", {28'd0, nvzc}, 32'h0);

      // table-driven immediate ALU: LDA #a ; CLC/SEC ; OP #m
      foreach (vecs[k]) begin
         hold_reset();
         mem[0] = 8'hA9; mem[1] = vecs[k].a; mem[2] = vecs[k].cin ? 8'h38 : 8'h18;
         mem[3] = vecs[k].op; mem[4] = vecs[k].m;
         release_reset();
         run_cycles(7);
         check($sformatf("vec%0d A", k), {24'd0, dut.a_q}, {24'd0, vecs[k].exp_a});
         check($sformatf("vec%0d NVZC", k), {28'd0, nvzc}, {28'd0, vecs[k].exp_nvzc});
         chk_cyc($sformatf("vec%0d next fetch", k), 6, 16'h0005, 1'b1);
      end

      // LDA #$7F ; ADC #$01 takes 4 cycles
      hold_reset();
      mem[0] = 8'hA9; mem[1] = 8'h7F; mem[2] = 8'h69; mem[3] = 8'h01;
      release_reset();
      run_cycles(5);
      chk_cyc("adc_ovf", 4, 16'h0004, 1'b1);
      check("adc_ovf A", {24'd0, dut.a_q}, 32'h80);
      check("adc_ovf NVZC", {28'd0, nvzc}, 32'b1100);

      // LDX #$00 ; STX $2000
      hold_reset();
      mem[0] = 8'hA2; mem[1] = 8'h00; mem[2] = 8'h8E; mem[3] = 8'h00; mem[4] = 8'h20;
      mem[16'h2000] = 8'hAA;
      n = wr_cnt;
      release_reset();
      run_cycles(7);
      for (int i = 0; i < 7; i++)
         if (i != 5) chk_cyc("stx", i, (i == 6) ? 16'h0005 : 16'(i), 1'b1);
      check("stx write cycle", {tr_addr[5], 7'd0, tr_rw[5], tr_data[5]}, {16'h2000, 7'd0, 1'b0, 8'h00});
      check("stx write count", wr_cnt - n, 32'd1);
      check("ldx Z", {31'd0, nvzc[1]}, 32'd1);

      // BEQ taken / BNE not taken after LDA #$00
      for (int b = 0; b < 2; b++) begin
         hold_reset();
         mem[0] = 8'hA9; mem[1] = 8'h00; mem[2] = (b == 0) ? 8'hF0 : 8'hD0; mem[3] = 8'h04;
         release_reset();
         run_cycles(5);
         chk_cyc(b == 0 ? "beq" : "bne", 3, 16'h0003, 1'b1);
         chk_cyc(b == 0 ? "beq" : "bne", 4, (b == 0) ? 16'h0008 : 16'h0004, 1'b1);
      end

      // JMP $FFFE then NOPs across the PC wrap
      hold_reset();
      mem[0] = 8'h4C; mem[1] = 8'hFE; mem[2] = 8'hFF;
      release_reset();
      run_cycles(8);
      begin
         logic [15:0] ja [0:7];
         ja = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
         for (int i = 0; i < 8; i++) chk_cyc("jmp_wrap", i, ja[i], 1'b1);
      end

      // reset asserted during the MEM cycle of STA
      hold_reset();
      mem[0] = 8'hA9; mem[1] = 8'h55; mem[2] = 8'h8D; mem[3] = 8'h00; mem[4] = 8'h30;
      release_reset();
      run_cycles(5);
      #1;
      check("sta mem cycle", {addr, 7'd0, rw, data}, {16'h3000, 7'd0, 1'b0, 8'h55});
      n = wr_cnt;
      reset = 1'b0;
      #1;
      check("async reset addr/rw", {addr, 15'd0, rw}, {16'h0000, 15'd0, 1'b1});
      check("async reset A", {24'd0, dut.a_q}, 32'h0);
      @(posedge clk);
      #1;
      check("no write under reset", wr_cnt - n, 32'd0);
      release_reset();
      run_cycles(2);
      chk_cyc("after reset", 0, 16'h0000, 1'b1);
      chk_cyc("after reset", 1, 16'h0001, 1'b1);

      // random memory images against the instruction-level model
      for (int s = 0; s < 4; s++) begin
         reset = 1'b0;
         for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 1) == 1) ? op_tab[$urandom_range(0, 30)] : 8'($urandom);
         model_run(250);
         n = e_addr.size();
         release_reset();
         run_cycles(n);
         for (int i = 0; i < n; i++)
            check($sformatf("rand%0d cyc%0d addr/rw/data", s, i),
                  {7'd0, tr_addr[i], tr_rw[i], tr_data[i]}, {7'd0, e_addr[i], e_rw[i], e_data[i]});
         check($sformatf("rand%0d AXY", s), {8'd0, dut.a_q, dut.x_q, dut.y_q}, {8'd0, m_a, m_x, m_y});
         check($sformatf("rand%0d NVZC", s), {28'd0, nvzc}, {28'd0, m_n, m_v, m_z, m_c});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
